// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: time-multiplexed scan controller for an NDIG-digit
// seven-segment display that shares a single sevenseg decoder.
// Holds a 4-bit code, dot bit and blink bit per digit. Each digit is shown
// for SCAN_DIV cycles, and DEAD_CYC all-off cycles separate the digits.
// Blinking digits go dark in alternate groups of BLINK_FRAMES frames.
// Optional feature macro: SEVENSEG_LZB_EN compiles in leading-zero blanking.
module sevenseg_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [$clog2(NDIG)-1:0] wr_idx,
  input  logic [3:0]              wr_data,
  input  logic                    wr_dot,
  input  logic                    wr_blink,
  input  logic                    hold,
  output logic [3:0]              enc,
  output logic                    dot,
  output logic [NDIG-1:0]         dig_sel,
  output logic                    blank,
  output logic                    scan_tick
);

  localparam int IW   = $clog2(NDIG);
  localparam int CMAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic {
    DEAD,
    SHOW
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [FW-1:0]   fcnt, fcnt_nx;
  logic            bph, bph_nx;
  logic            adv;

  logic [3:0]      digit [NDIG];
  logic [NDIG-1:0] dots;
  logic [NDIG-1:0] blinks;
  logic [NDIG-1:0] lzb;
  logic [NDIG-1:0] supp;

  // Digit register file; writes are always accepted, even during hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NDIG; i++) digit[i] <= '0;
      dots   <= '0;
      blinks <= '0;
    end else if (wr_en && (32'(wr_idx) < NDIG)) begin
      digit[wr_idx]  <= wr_data;
      dots[wr_idx]   <= wr_dot;
      blinks[wr_idx] <= wr_blink;
    end
  end

  // Scan sequencing: dwell/dead counting, digit advance, frame and blink phase.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    fcnt_nx  = fcnt;
    bph_nx   = bph;
    adv      = 1'b0;
    if (!hold) begin
      case (state)
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_nx = '0;
            if (DEAD_CYC > 0) state_nx = DEAD;
            else              adv      = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DEAD: begin
          if ((DEAD_CYC == 0) || (cnt == DEAD_LAST)) begin
            cnt_nx   = '0;
            state_nx = SHOW;
            adv      = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = DEAD;
      endcase
      if (adv) begin
        if (idx == IDX_LAST) begin
          idx_nx = '0;
          if (fcnt == FRAME_LAST) begin
            fcnt_nx = '0;
            bph_nx  = ~bph;
          end else begin
            fcnt_nx = fcnt + 1'b1;
          end
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
    end
  end

  // Scan state register; scan_tick marks the first cycle after an advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= DEAD;
      cnt       <= '0;
      idx       <= '0;
      fcnt      <= '0;
      bph       <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      fcnt      <= fcnt_nx;
      bph       <= bph_nx;
      scan_tick <= adv;
    end
  end

  // Per-digit suppression: blink phase, plus leading-zero blanking if built in.
  always_comb begin
    lzb = '0;
`ifdef SEVENSEG_LZB_EN
    begin : lzb_chain
      logic above;
      above = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
        above  = above & (digit[i] == 4'd0) & ~dots[i];
        lzb[i] = above;
      end
    end
`endif
    supp = lzb | (blinks & {NDIG{bph}});
  end

  // Digit select: only the current digit, only while showing and not suppressed.
  always_comb begin
    dig_sel = '1;
    if ((state == SHOW) && !supp[idx]) dig_sel[idx] = 1'b0;
  end

  assign enc   = digit[idx];
  assign dot   = dots[idx];
  assign blank = &dig_sel;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed bench for sevenseg_scan_ctrl with a
// slot-arithmetic reference model checked every cycle, plus literal checks.
// Honours SEVENSEG_LZB_EN the same way the design does.
module tb_sevenseg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int SDIV = 4;
  localparam int DCYC = 1;
  localparam int BFR  = 2;
  localparam int SLOT = SDIV + DCYC;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [3:0] wr_data;
  logic       wr_dot;
  logic       wr_blink;
  logic       hold;
  logic [3:0] enc;
  logic       dot;
  logic [3:0] dig_sel;
  logic       blank;
  logic       scan_tick;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_ctrl #(
    .NDIG(NDIG), .SCAN_DIV(SDIV), .DEAD_CYC(DCYC), .BLINK_FRAMES(BFR)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_dot(wr_dot), .wr_blink(wr_blink), .hold(hold), .enc(enc), .dot(dot),
    .dig_sel(dig_sel), .blank(blank), .scan_tick(scan_tick)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model state: active-cycle position since reset plus digit contents.
  int         p;
  logic       mtick;
  logic       mvalid = 1'b0;
  logic [3:0] mdig [NDIG];
  logic       mdot [NDIG];
  logic       mblk [NDIG];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the clock edge, mirroring the observable contract only.
  always @(posedge clk) begin
    mvalid <= 1'b1;
    if (!rst) begin
      p     <= 0;
      mtick <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        mdig[i] <= 4'd0;
        mdot[i] <= 1'b0;
        mblk[i] <= 1'b0;
      end
    end else begin
      if (wr_en) begin
        mdig[wr_idx] <= wr_data;
        mdot[wr_idx] <= wr_dot;
        mblk[wr_idx] <= wr_blink;
      end
      mtick <= !hold && ((p % SLOT) == DCYC - 1);
      if (!hold) p <= p + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    int   nadv, eidx, wraps;
    logic show, ebph, supp, lz;
    logic [3:0] esel;
    if (mvalid) begin
      show  = (p % SLOT) >= DCYC;
      nadv  = p / SLOT + (show ? 1 : 0);
      eidx  = nadv % NDIG;
      wraps = nadv / NDIG;
      ebph  = ((wraps / BFR) % 2) == 1;
      lz    = 1'b0;
`ifdef SEVENSEG_LZB_EN
      if (eidx >= 1) begin
        lz = 1'b1;
        for (int j = eidx; j < NDIG; j++)
          if (mdig[j] != 4'd0 || mdot[j]) lz = 1'b0;
      end
`endif
      supp = (mblk[eidx] && ebph) || lz;
      esel = 4'b1111;
      if (show && !supp) esel[eidx] = 1'b0;
      check_output("model_enc", 32'(enc), 32'(mdig[eidx]));
      check_output("model_dot", 32'(dot), 32'(mdot[eidx]));
      check_output("model_dig_sel", 32'(dig_sel), 32'(esel));
      check_output("model_blank", 32'(blank), 32'(esel == 4'b1111));
      check_output("model_scan_tick", 32'(scan_tick), 32'(mtick));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int i, input logic [3:0] d, input logic dt, input logic bl);
    wr_en    = 1'b1;
    wr_idx   = 2'(i);
    wr_data  = d;
    wr_dot   = dt;
    wr_blink = bl;
    step(1);
    wr_en = 1'b0;
  endtask

  // Waits (bounded) for a fresh arrival of dig_sel at the target pattern.
  task automatic wait_sel(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (dig_sel == target && n < 60) begin step(1); n++; end
    while (dig_sel != target && n < 60) begin step(1); n++; end
    check_output(name, 32'(dig_sel), 32'(target));
  endtask

  int ticks;
  int lit;

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_dot = 1'b0;
    wr_blink = 1'b0; hold = 1'b0;

    // Reset held for 3 cycles.
    step(3);
    check_output("rst_dig_sel", 32'(dig_sel), 32'h0F);
    check_output("rst_enc", 32'(enc), 32'h0);
    check_output("rst_blank", 32'(blank), 32'h1);
    check_output("rst_tick", 32'(scan_tick), 32'h0);

    // Release: one DEAD cycle, then digit 1 for four cycles.
    rst = 1'b1;
    check_output("rel_dead", 32'(dig_sel), 32'h0F);
    step(1);
    check_output("rel_first_show", 32'(dig_sel), 32'hD);
    check_output("rel_first_tick", 32'(scan_tick), 32'h1);
    step(3);
    check_output("rel_show_end", 32'(dig_sel), 32'hD);
    step(1);
    check_output("rel_dead2", 32'(blank), 32'h1);

    // Scan order with 3,5,A,F.
    apply_stimulus(0, 4'h3, 1'b0, 1'b0);
    apply_stimulus(1, 4'h5, 1'b0, 1'b0);
    apply_stimulus(2, 4'hA, 1'b1, 1'b0);
    apply_stimulus(3, 4'hF, 1'b0, 1'b0);
    wait_sel(4'b1110, "scan_sel0");
    check_output("scan_enc0", 32'(enc), 32'h3);
    wait_sel(4'b1101, "scan_sel1");
    check_output("scan_enc1", 32'(enc), 32'h5);
    wait_sel(4'b1011, "scan_sel2");
    check_output("scan_enc2", 32'(enc), 32'hA);
    check_output("scan_dot2", 32'(dot), 32'h1);
    wait_sel(4'b0111, "scan_sel3");
    check_output("scan_enc3", 32'(enc), 32'hF);
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      if (scan_tick) ticks++;
      step(1);
    end
    check_output("ticks_per_frame", 32'(ticks), 32'd4);

    // Hold after two cycles of digit 2.
    wait_sel(4'b1011, "hold_entry");
    step(2);
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check_output("hold_sel", 32'(dig_sel), 32'hB);
    end
    hold = 1'b0;
    check_output("hold_rel0", 32'(dig_sel), 32'hB);
    step(1);
    check_output("hold_rel1", 32'(dig_sel), 32'hB);
    step(1);
    check_output("hold_rel_dead", 32'(dig_sel), 32'hF);

    // Blink digit 1 over several blink periods.
    apply_stimulus(1, 4'h5, 1'b0, 1'b1);
    step(180);

    // Leading-zero pattern 0,0,7,0 for idx 3..0.
    apply_stimulus(3, 4'h0, 1'b0, 1'b0);
    apply_stimulus(2, 4'h0, 1'b0, 1'b0);
    apply_stimulus(1, 4'h7, 1'b0, 1'b0);
    apply_stimulus(0, 4'h0, 1'b0, 1'b0);
    step(5);
    lit = 0;
    for (int k = 0; k < 20; k++) begin
      if (!blank) lit++;
      step(1);
    end
`ifdef SEVENSEG_LZB_EN
    check_output("lzb_lit_0070", 32'(lit), 32'd8);
`else
    check_output("lzb_lit_0070", 32'(lit), 32'd16);
`endif
    apply_stimulus(1, 4'h0, 1'b0, 1'b0);
    step(5);
    lit = 0;
    for (int k = 0; k < 20; k++) begin
      if (!blank) lit++;
      step(1);
    end
`ifdef SEVENSEG_LZB_EN
    check_output("lzb_lit_0000", 32'(lit), 32'd4);
`else
    check_output("lzb_lit_0000", 32'(lit), 32'd16);
`endif

    // Reset mid-SHOW of digit 2; contents must be lost.
    apply_stimulus(2, 4'h9, 1'b1, 1'b0);
    wait_sel(4'b1011, "midrst_entry");
    rst = 1'b0;
    step(1);
    check_output("midrst_sel", 32'(dig_sel), 32'hF);
    rst = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step(1);
      check_output("midrst_enc", 32'(enc), 32'h0);
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
